// File: rtl/bk_arith_pkg.sv
// Shared arithmetic definitions for the Brent-Kung adder/subtractor family:
// default widths, the group generate/propagate pair and its prefix operator.
package bk_arith_pkg;

  localparam int WIDTH = 256;
  localparam int GROUP = 8;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // hi covers the more significant span, lo the span directly below it.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_borrow_prefix.sv
// Combinational Brent-Kung prefix over NG group (g, p) pairs, seeded by an
// incoming borrow (or carry); yields the borrow into every group and the final one.
module bk_borrow_prefix
  import bk_arith_pkg::*;
#(
  parameter int NG = 32
) (
  input  gp_t  [NG-1:0] i_gp,
  input  logic          i_seed,
  output logic [NG-1:0] o_bin,
  output logic          o_bout
);

  localparam int LVL = (NG > 1) ? $clog2(NG) : 1;

  gp_t [NG-1:0] w_node;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    w_node = i_gp;
    o_bin  = '0;
    // Up-sweep: node i absorbs the span of 2^l groups just below it.
    for (int l = 0; l < LVL; l++) begin
      for (int i = (1 << (l + 1)) - 1; i < NG; i += (1 << (l + 1))) begin
        w_node[i] = gp_combine(w_node[i], w_node[i - (1 << l)]);
      end
    end
    // Down-sweep fills the prefixes the up-sweep skipped.
    for (int l = LVL - 2; l >= 0; l--) begin
      for (int i = (1 << (l + 1)) + (1 << l) - 1; i < NG; i += (1 << (l + 1))) begin
        w_node[i] = gp_combine(w_node[i], w_node[i - (1 << l)]);
      end
    end
    o_bin[0] = i_seed;
    for (int k = 1; k < NG; k++) begin
      o_bin[k] = w_node[k - 1].g | (w_node[k - 1].p & i_seed);
    end
    o_bout = w_node[NG - 1].g | (w_node[NG - 1].p & i_seed);
  end

endmodule

// File: rtl/bk_sub_pipe.sv
// Three-stage pipelined subtractor diff = a - b - bin with valid/ready and
// bubble-collapsing backpressure. Define BK_SUB_OVERFLOW_EN to add the ovf output.
module bk_sub_pipe #(
  parameter int WIDTH = bk_arith_pkg::WIDTH,
  parameter int GROUP = bk_arith_pkg::GROUP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef BK_SUB_OVERFLOW_EN
  , output logic           ovf
`endif
);

  import bk_arith_pkg::*;

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_bad_width
    $error("bk_sub_pipe: WIDTH must be a multiple of GROUP");
  end

  logic r1_v, r2_v, r3_v;
  logic w_stall, w_en1, w_en2, w_en3, w_acc;

  logic [WIDTH-1:0] w_d0, w_d1, w_sel;
  gp_t  [NG-1:0]    w_gp;
  logic [NG-1:0]    w_bsel;
  logic             w_bout;

  logic [WIDTH-1:0] r1_d0, r1_d1, r2_d0, r2_d1, r3_diff;
  gp_t  [NG-1:0]    r1_gp;
  logic [NG-1:0]    r2_bsel;
  logic             r1_bin, r2_bout, r3_bout, r3_zero;
`ifdef BK_SUB_OVERFLOW_EN
  logic             r1_sx, r1_am, r2_sx, r2_am, r3_ovf;
`endif

  // A stage may load whenever its own content can move on or it holds a bubble.
  assign w_stall  = r3_v & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_en3    = ~w_stall;
  assign w_en2    = w_en3 | ~r2_v;
  assign w_en1    = w_en2 | ~r1_v;
  assign w_acc    = in_valid & in_ready;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [GROUP-1:0] w_a, w_b;
    assign w_a = a[k*GROUP +: GROUP];
    assign w_b = b[k*GROUP +: GROUP];
    assign w_d0[k*GROUP +: GROUP] = w_a - w_b;
    assign w_d1[k*GROUP +: GROUP] = w_a - w_b - 1'b1;
    assign w_gp[k] = {(w_a < w_b), (w_a == w_b)};
    assign w_sel[k*GROUP +: GROUP] = r2_bsel[k] ? r2_d1[k*GROUP +: GROUP]
                                                : r2_d0[k*GROUP +: GROUP];
  end

  bk_borrow_prefix #(
    .NG(NG)
  ) u_prefix (
    .i_gp  (r1_gp),
    .i_seed(r1_bin),
    .o_bin (w_bsel),
    .o_bout(w_bout)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and the stages shift together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_v <= 1'b0;
      r2_v <= 1'b0;
      r3_v <= 1'b0;
    end else begin
      if (w_en1) r1_v <= w_acc;
      if (w_en2) r2_v <= r1_v;
      if (w_en3) r3_v <= r2_v;
    end
  end

  // NOTE: the wide internal stage registers carry no reset; the valid bits
  // alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (w_en1 && w_acc) begin
      r1_d0  <= w_d0;
      r1_d1  <= w_d1;
      r1_gp  <= w_gp;
      r1_bin <= bin;
`ifdef BK_SUB_OVERFLOW_EN
      r1_sx  <= a[WIDTH-1] ^ b[WIDTH-1];
      r1_am  <= a[WIDTH-1];
`endif
    end
    if (w_en2 && r1_v) begin
      r2_d0   <= r1_d0;
      r2_d1   <= r1_d1;
      r2_bsel <= w_bsel;
      r2_bout <= w_bout;
`ifdef BK_SUB_OVERFLOW_EN
      r2_sx   <= r1_sx;
      r2_am   <= r1_am;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r3_diff <= '0;
      r3_bout <= 1'b0;
      r3_zero <= 1'b0;
`ifdef BK_SUB_OVERFLOW_EN
      r3_ovf  <= 1'b0;
`endif
    end else if (w_en3 && r2_v) begin
      r3_diff <= w_sel;
      r3_bout <= r2_bout;
      r3_zero <= ~|w_sel;
`ifdef BK_SUB_OVERFLOW_EN
      r3_ovf  <= r2_sx & (r2_am ^ w_sel[WIDTH-1]);
`endif
    end
  end

  assign out_valid = r3_v;
  assign diff      = r3_diff;
  assign bout      = r3_bout;
  assign zero      = r3_zero;
`ifdef BK_SUB_OVERFLOW_EN
  assign ovf       = r3_ovf;
`endif

endmodule

// File: doc/bk_sub_pipe.md
Name: bk_sub_pipe

Overview:
- Pipelined wide subtractor: computes DIFF = A - B - BIN using group borrow-generate/propagate and a Brent-Kung prefix tree over the groups.
- Inverse-operation companion to the team's pipelined Brent-Kung adder. Sits in the same arithmetic datapath.
- Adds a valid/ready handshake on both sides, with full backpressure, so it can sit between streaming stages.

Parameters:
- WIDTH, 256, operand width in bits; must be a multiple of GROUP.
- GROUP, 8, group size in bits; allowed values 1, 2, 4, 8, 16.
- NG, WIDTH/GROUP, number of groups; derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow in
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  out  1  borrow out; 1 when a < b + bin (unsigned)
- zero  out  1  diff == 0

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Reset clears all stage valid bits. Reset values: out_valid = 0, diff = 0, bout = 0, zero = 0. in_ready = 1 one cycle after reset deasserts.
- Pipeline: 3 register stages; fixed latency 3 cycles from an accepted beat to out_valid, when there is no stall.
- S1, per group:
  - borrow-generate g = 1 when the group's a < the group's b.
  - borrow-propagate p = 1 when the group's a == the group's b.
  - Register both local differences: borrow-in 0 and borrow-in 1.
  - Register bin.
- S2: Brent-Kung prefix over the NG (g, p) pairs, seeded by bin; register the borrow into each group and the final bout.
- S3: per group, select the local difference using that group's borrow-in. Compute zero as the NOR of the selected diff. Register diff, bout and zero.
- Stall rule: stall = out_valid & ~out_ready. When stall = 1, every stage holds its contents. in_ready = ~stall, combinational.
- Bubbles: an empty stage (valid = 0) advances even under stall only if a later stage is also empty. Bubbles collapse; throughput is 1 beat per cycle when out_ready = 1.
- Accept: a beat is accepted iff in_valid & in_ready; operands are sampled that edge. in_valid with in_ready = 0 is ignored; the source must hold.
- Output hold: while out_valid & ~out_ready, diff, bout and zero are stable.
- Ordering: results emerge in acceptance order; none are dropped or duplicated.
- Simultaneous accept and emit under out_ready = 1: both happen in the same cycle.
- Reset mid-operation: all in-flight beats are discarded; no partial result is emitted.
- Wrap-around: 0 - 1 gives diff = all ones, bout = 1. a == b with bin = 1 gives all ones, bout = 1.

Optional Feature:
- Macro: BK_SUB_OVERFLOW_EN.
- Defined:
  - Add output port ovf (1 bit), signed two's-complement overflow = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]).
  - ovf is pipelined alongside the other flags with the same latency.
  - Reset value 0; held under stall.
- Undefined: port absent; no extra logic.

Decomposition:
- Package bk_arith_pkg:
  - Default constants WIDTH and GROUP.
  - Typedef gp_t = struct {g, p}.
  - Function gp_combine(hi, lo) = {hi.g | hi.p & lo.g, hi.p & lo.p}.
- Sub-module bk_borrow_prefix:
  - Combinational Brent-Kung tree, parameter NG.
  - Inputs: gp_t array and seed borrow. Outputs: per-group borrow-in and final borrow.
  - Reusable by the adder, with g/p meaning carry.

Test Plan:
- Reset, then a = 5, b = 3, bin = 0, out_ready = 1 -> after 3 cycles: diff = 2, bout = 0, zero = 0, out_valid for 1 cycle.
- a = 0, b = 1, bin = 0 -> diff = 2^256 - 1 (all ones), bout = 1, zero = 0. With BK_SUB_OVERFLOW_EN: ovf = 0.
- a = b = 0x…DEADBEEF (repeating pattern), bin = 0 -> diff = 0, zero = 1, bout = 0. Same operands with bin = 1 -> all ones, bout = 1.
- Borrow ripple across all groups: a = 2^255, b = 1 -> diff = 2^255 - 1, bout = 0. With the macro: ovf = 1 (MSB flips positive).
- Backpressure:
  - Stimulus: stream 10 random beats back-to-back; hold out_ready = 0 for cycles 4–8.
  - in_ready drops while out_valid & ~out_ready. Outputs stay stable.
  - All 10 results match the reference model, in order, none lost or duplicated.
- Reset mid-stream: assert reset with 3 beats in flight -> out_valid = 0 immediately (asynchronous). No stale result appears after release; the next beat has 3-cycle latency.
